// File: rtl/pc_ctrl.sv
// pc_ctrl: multicycle fetch/retire sequencer driving the control-unit side of
// the PC interface.
//   CLK, nRST        clock (rising edge) / asynchronous active-low reset
//   ihit, imemload   instruction read complete / fetched instruction word
//   dhit             data memory access complete
//   zero             ALU zero flag for the held instruction
//   imemREN          instruction read request (FETCH only)
//   dmemREN, dmemWEN data read (LW) / write (SW) request (MEM only)
//   instr            held instruction word
//   pcif (pc_if.cu)  pcEn, pcSel, immJ26, ext32 towards the PC
//   halt             high once a HALT has executed, until reset
//   retired          retired-instruction count, wraps modulo 2^CNT_W

package pc_ctrl_pkg;
  // Next-PC source selection
  typedef enum logic [1:0] {
    PC_NPC = 2'd0,
    PC_BR  = 2'd1,
    PC_J   = 2'd2,
    PC_JR  = 2'd3
  } pcMux;
endpackage

// Control-unit <-> PC register handshake bundle
interface pc_if;
  import pc_ctrl_pkg::*;
  logic        pcEn;
  pcMux        pcSel;
  logic [25:0] immJ26;
  logic [31:0] ext32;
  modport cu (output pcEn, pcSel, immJ26, ext32);
  modport pc (input pcEn, pcSel, immJ26, ext32);
endinterface

module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  input  logic             dhit,
  input  logic             zero,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      instr,
  pc_if.cu                 pcif,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MEM    = 2'd2,
    HALTED = 2'd3
  } ctrlState;

  ctrlState   state;
  ctrlState   nextState;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       isLw;
  logic       isSw;
  logic       isMem;
  logic       isHalt;
  pcMux       decSel;
  logic       pcEnInt;

  // Instruction decode of the held word
  always_comb begin
    opcode = instr[31:26];
    funct  = instr[5:0];
    isLw   = (opcode == OP_LW);
    isSw   = (opcode == OP_SW);
    isMem  = isLw || isSw;
    isHalt = (opcode == OP_HALT);
    decSel = PC_NPC;
    unique case (opcode)
      OP_J, OP_JAL: decSel = PC_J;
      OP_BEQ:       decSel = zero ? PC_BR : PC_NPC;
      OP_BNE:       decSel = zero ? PC_NPC : PC_BR;
      OP_RTYPE:     decSel = (funct == FN_JR) ? PC_JR : PC_NPC;
      default:      decSel = PC_NPC;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FETCH;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      FETCH:  if (ihit) nextState = EXEC;
      EXEC: begin
        if (isHalt)     nextState = HALTED;
        else if (isMem) nextState = MEM;
        else            nextState = FETCH;
      end
      MEM:    if (dhit) nextState = FETCH;
      HALTED: nextState = HALTED;
      default: nextState = FETCH;
    endcase
  end

  // Outputs decoded from the registered state plus live zero/dhit
  always_comb begin
    imemREN = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    pcEnInt = 1'b0;
    halt    = 1'b0;
    unique case (state)
      FETCH:  imemREN = 1'b1;
      EXEC:   pcEnInt = !isHalt && !isMem;
      MEM: begin
        dmemREN = isLw;
        dmemWEN = isSw;
        pcEnInt = dhit;
      end
      HALTED: halt = 1'b1;
      default: ;
    endcase
  end

  assign pcif.pcEn   = pcEnInt;
  assign pcif.pcSel  = decSel;
  assign pcif.immJ26 = instr[25:0];
  assign pcif.ext32  = {{16{instr[15]}}, instr[15:0]};

  // Instruction latch and retire counter (one count per PC update)
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr   <= 32'h0;
      retired <= '0;
    end else begin
      if (state == FETCH && ihit) instr <= imemload;
      if (pcEnInt) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an instruction-level model.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned RET_MOD = 1 << CNT_W;
  localparam int P_FETCH = 0;
  localparam int P_EXEC  = 1;
  localparam int P_MEM   = 2;
  localparam int P_STOP  = 3;

  logic             CLK  = 1'b0;
  logic             nRST = 1'b1;
  logic             ihit = 1'b0;
  logic             dhit = 1'b0;
  logic             zero = 1'b0;
  logic [31:0]      imemload = 32'h0;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic             halt;
  logic [31:0]      instr;
  logic [CNT_W-1:0] retired;

  pc_if pcif();

  pc_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .dhit(dhit),
    .zero(zero), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .instr(instr), .pcif(pcif), .halt(halt), .retired(retired)
  );

  always #5 CLK = ~CLK;

  int          nTests = 0;
  int          nFail  = 0;
  int          mPhase = P_FETCH;
  logic [31:0] mInstr = 32'h0;
  int          mRetired = 0;
  int          haltCycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Next-PC source implied by the instruction semantics
  function automatic logic [1:0] expSrc(input logic [31:0] w, input logic z);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'h02 || op == 6'h03) return 2'(PC_J);
    if (op == 6'h04) return z ? 2'(PC_BR) : 2'(PC_NPC);
    if (op == 6'h05) return z ? 2'(PC_NPC) : 2'(PC_BR);
    if (op == 6'h00 && w[5:0] == 6'h08) return 2'(PC_JR);
    return 2'(PC_NPC);
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[31:26] = 6'h04;
      1: w[31:26] = 6'h05;
      2: w[31:26] = 6'h02;
      3: w[31:26] = 6'h03;
      4: begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
      5: w[31:26] = 6'h23;
      6: w[31:26] = 6'h2B;
      7: w[31:26] = 6'h00;
      8: w[31:26] = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'h08;
      default: ;
    endcase
    return w;
  endfunction

  // One clock cycle: drive inputs, compare against the model, advance the model
  task automatic step(input logic ih, input logic [31:0] im, input logic dh, input logic z);
    logic [5:0] op;
    logic       memOp;
    logic       haltOp;
    logic       retire;
    logic [4:0] expCtl;
    logic [31:0] expExt;
    @(negedge CLK);
    ihit = ih; imemload = im; dhit = dh; zero = z;
    #1;
    op     = mInstr[31:26];
    memOp  = (op == 6'h23) || (op == 6'h2B);
    haltOp = (op == 6'h3F);
    retire = (mPhase == P_EXEC && !memOp && !haltOp) || (mPhase == P_MEM && dh);
    expCtl = {mPhase == P_FETCH, mPhase == P_MEM && op == 6'h23,
              mPhase == P_MEM && op == 6'h2B, retire, mPhase == P_STOP};
    expExt = mInstr[15] ? (32'hFFFF0000 | (mInstr & 32'h0000FFFF)) : (mInstr & 32'h0000FFFF);
    chk("ctl{iREN,dREN,dWEN,pcEn,halt}",
        32'({imemREN, dmemREN, dmemWEN, pcif.pcEn, halt}), 32'(expCtl));
    chk("pcSel", 32'(pcif.pcSel), 32'(expSrc(mInstr, z)));
    chk("immJ26", 32'(pcif.immJ26), mInstr & 32'h03FFFFFF);
    chk("ext32", pcif.ext32, expExt);
    chk("instr", instr, mInstr);
    chk("retired", 32'(retired), 32'(mRetired));
    if (retire) mRetired = (mRetired + 1) % int'(RET_MOD);
    case (mPhase)
      P_FETCH: if (ih) begin mInstr = im; mPhase = P_EXEC; end
      P_EXEC:  mPhase = haltOp ? P_STOP : (memOp ? P_MEM : P_FETCH);
      P_MEM:   if (dh) mPhase = P_FETCH;
      default: ;
    endcase
  endtask

  task automatic applyReset();
    nRST = 1'b0;
    ihit = 1'b0; dhit = 1'b0; zero = 1'b0; imemload = 32'h0;
    mPhase = P_FETCH; mInstr = 32'h0; mRetired = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic runInstr(input logic [31:0] w);
    step(1'b1, w, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    applyReset();
    #1;
    chk("rst imemREN", 32'(imemREN), 32'd1);
    chk("rst pcEn", 32'(pcif.pcEn), 32'd0);
    chk("rst pcSel", 32'(pcif.pcSel), 32'(PC_NPC));
    chk("rst immJ26", 32'(pcif.immJ26), 32'd0);
    chk("rst ext32", pcif.ext32, 32'd0);
    chk("rst dmem", 32'({dmemREN, dmemWEN}), 32'd0);
    chk("rst halt", 32'(halt), 32'd0);
    chk("rst retired", 32'(retired), 32'd0);

    // NOP-like word 0
    step(1'b1, 32'h0, 1'b0, 1'b0);
    chk("nop fetch imemREN", 32'(imemREN), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("nop exec pcEn", 32'(pcif.pcEn), 32'd1);
    chk("nop exec pcSel", 32'(pcif.pcSel), 32'(PC_NPC));
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("nop retired", 32'(retired), 32'd1);
    chk("nop back imemREN", 32'(imemREN), 32'd1);

    // BEQ taken / not taken
    step(1'b1, 32'h1022FFFE, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("beq z1 pcSel", 32'(pcif.pcSel), 32'(PC_BR));
    chk("beq ext32", pcif.ext32, 32'hFFFFFFFE);
    chk("beq pcEn", 32'(pcif.pcEn), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("beq pcEn next", 32'(pcif.pcEn), 32'd0);
    step(1'b1, 32'h1022FFFE, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("beq z0 pcSel", 32'(pcif.pcSel), 32'(PC_NPC));

    // BNE inverse choices
    step(1'b1, 32'h1422FFFE, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("bne z1 pcSel", 32'(pcif.pcSel), 32'(PC_NPC));
    step(1'b1, 32'h1422FFFE, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bne z0 pcSel", 32'(pcif.pcSel), 32'(PC_BR));

    // J and JR
    step(1'b1, 32'h08100004, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("j pcSel", 32'(pcif.pcSel), 32'(PC_J));
    chk("j immJ26", 32'(pcif.immJ26), 32'h0100004);
    step(1'b1, 32'h03E00008, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("jr pcSel", 32'(pcif.pcSel), 32'(PC_JR));

    // LW with dhit on the third memory cycle
    step(1'b1, 32'h8C220010, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lw exec pcEn", 32'(pcif.pcEn), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, (i == 2), 1'b0);
      chk("lw dmemREN", 32'(dmemREN), 32'd1);
      chk("lw dmemWEN", 32'(dmemWEN), 32'd0);
      chk("lw pcEn", 32'(pcif.pcEn), (i == 2) ? 32'd1 : 32'd0);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("lw retired", 32'(retired), 32'd8);
    chk("spurious dhit pcEn", 32'(pcif.pcEn), 32'd0);
    chk("spurious dhit instr", instr, 32'h8C220010);

    // SW
    step(1'b1, 32'hAC220010, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sw dmemWEN", 32'(dmemWEN), 32'd1);
    chk("sw dmemREN", 32'(dmemREN), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("sw pcEn", 32'(pcif.pcEn), 32'd1);

    // HALT is absorbing and not counted
    step(1'b1, 32'hFC000000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("halt exec pcEn", 32'(pcif.pcEn), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(1'($urandom_range(0, 1)), randInstr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("halted halt", 32'(halt), 32'd1);
      chk("halted reqs", 32'({pcif.pcEn, imemREN, dmemREN, dmemWEN}), 32'd0);
    end
    chk("halted retired", 32'(retired), 32'd9);
    nRST = 1'b0;
    #1;
    chk("halt reset halt", 32'(halt), 32'd0);
    chk("halt reset imemREN", 32'(imemREN), 32'd1);
    applyReset();

    // Counter wrap at 2^CNT_W
    for (int i = 0; i < 15; i++) runInstr(32'h20420001);
    @(posedge CLK); #1;
    chk("wrap pre", 32'(retired), 32'd15);
    runInstr(32'h20420001);
    @(posedge CLK); #1;
    chk("wrap post", 32'(retired), 32'd0);

    // Reset in the middle of a load
    runInstr(32'h0);
    step(1'b1, 32'h8C220010, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("midmem dmemREN before", 32'(dmemREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("midmem dmemREN", 32'(dmemREN), 32'd0);
    chk("midmem pcEn", 32'(pcif.pcEn), 32'd0);
    chk("midmem retired", 32'(retired), 32'd0);
    applyReset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (mPhase == P_STOP) begin
        haltCycles++;
        if (haltCycles > 12) begin
          applyReset();
          haltCycles = 0;
        end
      end
      step(1'($urandom_range(0, 1)), randInstr(), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", nFail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Multicycle fetch/retire sequencer that drives the control-unit side of the PC interface (pcEn, pcSel, immJ26, ext32). It fetches an instruction from instruction memory and holds it for the datapath. For loads and stores it waits on data memory. It then issues exactly one PC update per retired instruction, choosing the next-PC source from the held instruction and the ALU zero flag. It sits between the memory hit signals and the PC register, and it stops the PC permanently on HALT.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction memory read complete; imemload valid this cycle
- imemload  in  32  instruction word from instruction memory
- dhit  in  1  data memory access complete
- zero  in  1  ALU zero flag, computed combinationally from the held instruction
- imemREN  out  1  instruction memory read request
- dmemREN  out  1  data memory read request (LW)
- dmemWEN  out  1  data memory write request (SW)
- instr  out  32  held instruction word, to decode and register file
- pcif  pc_if.cu  —  drives pcEn (1), pcSel (pcMux), immJ26 (26), ext32 (32)
- halt  out  1  sticky halt indication
- retired  out  CNT_W  count of retired instructions

## Operation
- Opcode decode uses instr[31:26]:
  - 0x02 J, 0x03 JAL → PC_J
  - 0x04 BEQ → PC_BR if zero, else PC_NPC
  - 0x05 BNE → PC_BR if !zero, else PC_NPC
  - 0x00 with funct instr[5:0]=0x08 (JR) → PC_JR
  - 0x23 LW, 0x2B SW → memory instructions, PC_NPC
  - 0x3F → HALT
  - all other opcodes → PC_NPC
- immJ26 = instr[25:0] at all times.
- ext32 = {{16{instr[15]}}, instr[15:0]}, always sign-extended.
- The PC applies the ×4 scaling and adds the offset; this block does not.
- FSM states: FETCH, EXEC, MEM, HALTED.
- FETCH:
  - imemREN=1.
  - On ihit: instr <= imemload, go to EXEC.
  - Without ihit: stay in FETCH, instr unchanged.
- EXEC (exactly one cycle):
  - HALT opcode → HALTED; pcEn=0.
  - LW/SW → MEM; pcEn=0.
  - Otherwise → FETCH; pcEn=1; pcSel as decoded; retired increments.
- MEM:
  - dmemREN=1 for LW, dmemWEN=1 for SW; held until dhit.
  - On dhit: pcEn=1, pcSel=PC_NPC, retired increments, go to FETCH.
- HALTED:
  - Absorbing until nRST.
  - halt=1; pcEn=0; all memory requests 0.
  - HALT is not counted in retired.
- Outputs are decoded from the registered state, instr and the live zero/dhit inputs. No request is asserted outside its owning state.
- retired wraps modulo 2^CNT_W, so all-ones + 1 → 0.
- When pcEn=0, pcSel still shows the decode of instr; the PC ignores it.

## Timing
- Reset (nRST low, asynchronous): state=FETCH, instr=0, retired=0, halt=0.
  - Resulting outputs: imemREN=1 once state is FETCH, pcEn=0, pcSel=PC_NPC (instr=0 decodes to NPC), immJ26=0, ext32=0, dmemREN=dmemWEN=0.
- Non-memory instruction: ihit cycle, then EXEC cycle with pcEn=1. The PC holds its new value one edge after EXEC. Minimum 2 cycles per instruction.
- Memory instruction: ihit cycle, EXEC, then N≥1 MEM cycles. pcEn=1 in the dhit cycle. Minimum 3 cycles.
- pcEn is high for exactly one cycle per retired instruction. It is never high in two consecutive cycles.
- ihit outside FETCH is ignored; dhit outside MEM is ignored.
- zero is sampled only in the EXEC cycle.
- Reset asserted during MEM aborts the access: dmemREN/dmemWEN drop asynchronously, no pcEn is issued, and retired is cleared.
- Reset during HALTED returns to FETCH with halt=0.

## Test plan
- Reset, then ihit with imemload=0x00000000 → instr=0; EXEC cycle pcEn=1, pcSel=PC_NPC; retired=1; back to FETCH with imemREN=1.
- BEQ 0x1022FFFE, zero=1 → pcSel=PC_BR, ext32=0xFFFFFFFE, pcEn=1 for one cycle. Repeat with zero=0 → PC_NPC. Same instruction as BNE (0x1422FFFE) → inverse choices.
- J 0x0810_0004 → pcSel=PC_J, immJ26=0x0100004. JR 0x03E00008 → pcSel=PC_JR.
- LW 0x8C220010 with dhit delayed 3 cycles → dmemREN=1 for 3 cycles, dmemWEN=0, pcEn=1 only in the dhit cycle, retired +1. SW 0xAC220010 → dmemWEN analog. Inject a spurious dhit during FETCH → no effect.
- HALT 0xFC000000 → halt=1 from the next cycle; pcEn, imemREN, dmemREN and dmemWEN stay 0 for 10+ cycles despite ihit/dhit pulses; retired unchanged. Then pulse nRST → halt=0, state FETCH.
- Preload retired to all-ones (CNT_W=4, 15 retirements), retire one more → retired=0. Assert nRST mid-MEM → dmemREN=0 immediately, no pcEn, retired=0.
